// File: rtl/fetch_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue_pkg
//  Description : Shared fetch/decode types. Holds the packet passed from
//                fetch to decode (pipe_in_t), the fetch queue depth used by
//                decode and the ROB for credit sizing, and the queue FSM
//                state enumeration.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_queue_pkg;

    localparam int FQ_DEPTH = 8;
    localparam int FQ_RAS_W = 3;

    typedef struct packed {
        logic [31:0]         pc;
        logic [31:0]         instruction;
        logic                prediction;
        logic                branch;
        logic                jump;
        logic [FQ_RAS_W-1:0] ras_ptr;
        logic [31:0]         jalr_address;
        logic [7:0]          mcause;
        logic                exception;
    } pipe_in_t;

    typedef enum logic [0:0] {
        FQ_RUN  = 1'b0,
        FQ_HOLD = 1'b1
    } fq_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue_if
//  Description : Handshake bundle around the fetch queue.
//                slave  : the queue itself (enqueue/dequeue/flush inputs,
//                         status and head entry outputs)
//                master : the surrounding pipeline (fetch, decode, commit)
//  Ports       : enq_valid/enq_data/full   - fetch side
//                deq_ready/deq_valid/deq_data - decode side
//                flush                     - redirect from commit
//                count/hold                - occupancy and freeze status
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_queue_if #(
    parameter int DEPTH = fetch_queue_pkg::FQ_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) ();
    import fetch_queue_pkg::*;

    logic           enq_valid;
    pipe_in_t       enq_data;
    logic           full;
    logic           deq_ready;
    logic           deq_valid;
    pipe_in_t       deq_data;
    logic           flush;
    logic [PTR_W:0] count;
    logic           hold;

    modport slave (
        input  enq_valid, enq_data, deq_ready, flush,
        output full, deq_valid, deq_data, count, hold
    );

    modport master (
        output enq_valid, enq_data, deq_ready, flush,
        input  full, deq_valid, deq_data, count, hold
    );

endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : Decoupling FIFO between fetch and decode. Buffers one
//                pipe_in_t per enqueue, back-pressures fetch through full,
//                discards everything on flush, and freezes enqueue once a
//                faulting packet has been captured until the next flush.
//  Ports       : clk    - rising-edge clock
//                reset  - synchronous, active-high
//                q_if   - fetch_queue_if.slave handshake bundle
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         reset,
    fetch_queue_if.slave q_if
);

    localparam logic [0:0]     C_RUN  = 1'(FQ_RUN);
    localparam logic [0:0]     C_HOLD = 1'(FQ_HOLD);
    localparam logic [PTR_W:0] C_FULL = (PTR_W+1)'(DEPTH);

    pipe_in_t         mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [0:0]       state_q, state_d;

    logic             w_full;
    logic             w_deq_valid;
    logic             w_enq_fire;
    logic             w_deq_fire;
    pipe_in_t         w_deq_data;

    always_comb begin
        // full depends only on registered state, so deq_ready never reaches
        // the fetch stall path combinationally.
        w_full      = (count_q == C_FULL) || (state_q == C_HOLD);
        w_deq_valid = (count_q != '0);
        w_deq_data  = w_deq_valid ? mem_q[head_q] : '0;

        // flush wins over both handshakes in the same cycle.
        w_enq_fire  = q_if.enq_valid && !w_full && !q_if.flush;
        w_deq_fire  = q_if.deq_ready && w_deq_valid && !q_if.flush;

        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        state_d = state_q;

        if (q_if.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            state_d = C_RUN;
        end else begin
            // Power-of-two depth: pointers wrap by plain overflow.
            if (w_enq_fire) begin
                tail_d = tail_q + 1'b1;
            end
            if (w_deq_fire) begin
                head_d = head_q + 1'b1;
            end
            case ({w_enq_fire, w_deq_fire})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            // The faulting packet itself is stored; everything after it is
            // wrong-path until commit redirects with a flush.
            if (w_enq_fire && q_if.enq_data.exception) begin
                state_d = C_HOLD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            state_q <= C_RUN;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            state_q <= state_d;
            if (w_enq_fire) begin
                mem_q[tail_q] <= q_if.enq_data;
            end
        end
    end

    assign q_if.full      = w_full;
    assign q_if.deq_valid = w_deq_valid;
    assign q_if.deq_data  = w_deq_data;
    assign q_if.count     = count_q;
    assign q_if.hold      = (state_q == C_HOLD);

endmodule
`default_nettype wire
